rc4_phase_sched: RTL and testbench

- Top-level sequencer for the RC4 key-search datapath.
- Owns the single-port 256x8 S-memory and grants it to one of three phase engines at a time: init (S[i]=i), KSA swap, and PRGA/decrypt.
- Steps the 24-bit candidate key through a range, pulses start_over between attempts, and reports found or fail.

---
 rtl/rc4_phase_sched.sv | 192 +++++++++++++++++++
 tb/tb_rc4_phase_sched.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_phase_sched.sv
// rc4_phase_sched: top-level sequencer for the RC4 key-search datapath.
// It owns the single-port 256x8 S-memory and grants it to exactly one phase
// engine at a time (init, KSA, PRGA). It also steps the 24-bit candidate key,
// pulses start_over between attempts, and reports found / fail.
//
// Optional feature: define RC4_PHASE_TIMEOUT_EN to add a per-phase cycle
// limit (TIMEOUT). If the limit is reached, the search ends in FAIL with
// timeout_err set. Without the macro, timeout_err is tied 0 and each phase
// waits on its done flag indefinitely.
//
// Handshake: start is a one-cycle request. It is accepted only while busy=0
// (IDLE, FOUND, FAIL). Each engine's done flag is a level. It is sampled only
// in the state that owns that engine. Engines drop their done flags on the
// start_over pulse, so a stale done is never seen by the next attempt.
module rc4_phase_sched #(
    parameter logic [23:0] KEY_START = 24'h000000,
    parameter logic [23:0] KEY_END   = 24'h3FFFFF,
    parameter logic [19:0] TIMEOUT   = 20'd100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        init_done,
    input  logic        ksa_done,
    input  logic        prga_done,
    input  logic        prga_pass,
    input  logic [7:0]  init_addr,
    input  logic [7:0]  ksa_addr,
    input  logic [7:0]  prga_addr,
    input  logic [7:0]  init_wrdata,
    input  logic [7:0]  ksa_wrdata,
    input  logic [7:0]  prga_wrdata,
    input  logic        init_wren,
    input  logic        ksa_wren,
    input  logic        prga_wren,
    output logic [7:0]  s_addr,
    output logic [7:0]  s_wrdata,
    output logic        s_wren,
    output logic        init_go,
    output logic        ksa_go,
    output logic        prga_go,
    output logic        start_over,
    output logic [23:0] key,
    output logic        busy,
    output logic        found,
    output logic        fail,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_KSA,
        S_PRGA,
        S_CHECK,
        S_NEXT_KEY,
        S_FOUND,
        S_FAIL
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   pass_q;
    logic   accept_start;
    logic   in_phase;
    logic   phase_done;

    // A new search is accepted only from a resting state.
    assign accept_start = start && !busy;

    // Decode whether the FSM is waiting on an engine, and that engine's done flag.
    always_comb begin
        in_phase   = 1'b0;
        phase_done = 1'b0;
        case (state_q)
            S_INIT: begin in_phase = 1'b1; phase_done = init_done; end
            S_KSA:  begin in_phase = 1'b1; phase_done = ksa_done;  end
            S_PRGA: begin in_phase = 1'b1; phase_done = prga_done; end
            default: begin in_phase = 1'b0; phase_done = 1'b0; end
        endcase
    end

`ifdef RC4_PHASE_TIMEOUT_EN
    logic [19:0] timer_q;
    logic        tmo_hit;

    // The limit fires on the last allowed cycle of a phase unless done arrives in that cycle.
    assign tmo_hit = in_phase && !phase_done && (timer_q == TIMEOUT - 20'd1);

    // Phase timer: cleared on every state change, counts cycles spent inside a phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else if (state_d != state_q) begin
            timer_q <= '0;
        end else if (in_phase) begin
            timer_q <= timer_q + 20'd1;
        end
    end

    // Sticky timeout flag, cleared when the next search is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if (accept_start) begin
            timeout_err <= 1'b0;
        end else if (tmo_hit) begin
            timeout_err <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_err    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_FOUND, S_FAIL: if (start) state_d = S_INIT;
            S_INIT:     if (init_done) state_d = S_KSA;
            S_KSA:      if (ksa_done)  state_d = S_PRGA;
            S_PRGA:     if (prga_done) state_d = S_CHECK;
            // '>=' also ends the search after one attempt when KEY_START > KEY_END.
            S_CHECK: begin
                if (pass_q)              state_d = S_FOUND;
                else if (key >= KEY_END) state_d = S_FAIL;
                else                     state_d = S_NEXT_KEY;
            end
            S_NEXT_KEY: state_d = S_INIT;
            default:    state_d = S_IDLE;
        endcase
`ifdef RC4_PHASE_TIMEOUT_EN
        if (tmo_hit) state_d = S_FAIL;
`endif
    end

    // Candidate key: reloaded on an accepted start, stepped once per retry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key <= KEY_START;
        end else if (accept_start) begin
            key <= KEY_START;
        end else if (state_q == S_NEXT_KEY) begin
            key <= key + 24'd1;
        end
    end

    // Capture the PRGA verdict on the same edge that leaves PRGA.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_q <= 1'b0;
        end else if (state_q == S_PRGA && prga_done) begin
            pass_q <= prga_pass;
        end
    end

    // Moore control outputs, decoded from the registered state only.
    always_comb begin
        init_go    = (state_q == S_INIT);
        ksa_go     = (state_q == S_KSA);
        prga_go    = (state_q == S_PRGA);
        start_over = (state_q == S_NEXT_KEY);
        found      = (state_q == S_FOUND);
        fail       = (state_q == S_FAIL);
        busy       = !(state_q == S_IDLE || state_q == S_FOUND || state_q == S_FAIL);
    end

    // S-memory grant: only the owning engine's port reaches the memory.
    always_comb begin
        s_addr   = 8'h00;
        s_wrdata = 8'h00;
        s_wren   = 1'b0;
        case (state_q)
            S_INIT: begin s_addr = init_addr; s_wrdata = init_wrdata; s_wren = init_wren; end
            S_KSA:  begin s_addr = ksa_addr;  s_wrdata = ksa_wrdata;  s_wren = ksa_wren;  end
            S_PRGA: begin s_addr = prga_addr; s_wrdata = prga_wrdata; s_wren = prga_wren; end
            default: begin s_addr = 8'h00; s_wrdata = 8'h00; s_wren = 1'b0; end
        endcase
    end

endmodule

// File: tb/tb_rc4_phase_sched.sv
// Bench for rc4_phase_sched. Three instances share engine-side inputs:
//   0: KEY_START=0, KEY_END=3FFFFF   1: KEY_START=0, KEY_END=2
//   2: KEY_START=5, KEY_END=2 (single attempt)
// Only the selected instance (sel) drives the engine stubs and the monitor.
// The other instances each have their own start line, so they stay idle.
module tb_rc4_phase_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0] start_v   = '0;
    logic [1:0] sel       = 2'd0;
    int         pass_mode = 0;   // 0 never, 1 always, 2 only key==3
    logic       stall_ksa = 1'b0;

    logic       init_done = 1'b0, ksa_done = 1'b0, prga_done = 1'b0, prga_pass = 1'b0;
    logic [7:0] init_addr = '0, ksa_addr = '0, prga_addr = '0;
    logic [7:0] init_wrdata = '0, ksa_wrdata = '0, prga_wrdata = '0;
    logic       init_wren = 1'b0, ksa_wren = 1'b0, prga_wren = 1'b0;

    logic [7:0]  o_s_addr [3];
    logic [7:0]  o_s_wrdata [3];
    logic [23:0] o_key [3];
    logic        o_s_wren [3], o_init_go [3], o_ksa_go [3], o_prga_go [3];
    logic        o_start_over [3], o_busy [3], o_found [3], o_fail [3], o_tmo [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        rc4_phase_sched #(
            .KEY_START((g == 2) ? 24'd5 : 24'd0),
            .KEY_END  ((g == 0) ? 24'h3FFFFF : 24'd2),
            .TIMEOUT  (20'd50)
        ) dut (
            .clk(clk), .rst(rst), .start(start_v[g]),
            .init_done(init_done), .ksa_done(ksa_done), .prga_done(prga_done),
            .prga_pass(prga_pass),
            .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
            .init_wrdata(init_wrdata), .ksa_wrdata(ksa_wrdata), .prga_wrdata(prga_wrdata),
            .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
            .s_addr(o_s_addr[g]), .s_wrdata(o_s_wrdata[g]), .s_wren(o_s_wren[g]),
            .init_go(o_init_go[g]), .ksa_go(o_ksa_go[g]), .prga_go(o_prga_go[g]),
            .start_over(o_start_over[g]), .key(o_key[g]), .busy(o_busy[g]),
            .found(o_found[g]), .fail(o_fail[g]), .timeout_err(o_tmo[g])
        );
    end

    logic [7:0]  m_s_addr, m_s_wrdata;
    logic [23:0] m_key;
    logic        m_s_wren, m_init_go, m_ksa_go, m_prga_go, m_start_over;
    logic        m_busy, m_found, m_fail, m_tmo;

    always_comb begin
        m_s_addr     = o_s_addr[sel];
        m_s_wrdata   = o_s_wrdata[sel];
        m_s_wren     = o_s_wren[sel];
        m_key        = o_key[sel];
        m_init_go    = o_init_go[sel];
        m_ksa_go     = o_ksa_go[sel];
        m_prga_go    = o_prga_go[sel];
        m_start_over = o_start_over[sel];
        m_busy       = o_busy[sel];
        m_found      = o_found[sel];
        m_fail       = o_fail[sel];
        m_tmo        = o_tmo[sel];
    end

    // Engine stubs: each done rises 10 cycles after its go, holds until start_over/start/rst.
    int c_init = 0, c_ksa = 0, c_prga = 0;
    always @(negedge clk) begin
        if (rst || m_start_over || (|start_v)) begin
            init_done = 1'b0; ksa_done = 1'b0; prga_done = 1'b0; prga_pass = 1'b0;
            c_init = 0; c_ksa = 0; c_prga = 0;
        end else begin
            if (m_init_go && !init_done) begin
                c_init++;
                if (c_init >= 10) init_done = 1'b1;
            end
            if (m_ksa_go && !ksa_done && !stall_ksa) begin
                c_ksa++;
                if (c_ksa >= 10) ksa_done = 1'b1;
            end
            if (m_prga_go && !prga_done) begin
                c_prga++;
                if (c_prga >= 10) begin
                    prga_done = 1'b1;
                    prga_pass = (pass_mode == 1) || (pass_mode == 2 && m_key == 24'h000003);
                end
            end
        end
    end

    // Monitor: phase order log, start_over pulse counts, overlapping go detection.
    logic [1:0] phase_log[$];
    int  so_total = 0, so_long = 0, so_run = 0, multi_go = 0;
    logic p_init = 1'b0, p_ksa = 1'b0, p_prga = 1'b0;
    always @(negedge clk) begin
        if (m_init_go && !p_init) phase_log.push_back(2'd1);
        if (m_ksa_go  && !p_ksa)  phase_log.push_back(2'd2);
        if (m_prga_go && !p_prga) phase_log.push_back(2'd3);
        p_init = m_init_go; p_ksa = m_ksa_go; p_prga = m_prga_go;
        if (m_start_over) begin
            so_run++;
            if (so_run == 1) so_total++;
            if (so_run == 2) so_long++;
        end else begin
            so_run = 0;
        end
        if (int'(m_init_go) + int'(m_ksa_go) + int'(m_prga_go) > 1) multi_go++;
    end

    // Scoreboard: {found, fail, timeout_err, key, start_over pulses}.
    logic [34:0] exp_q[$];
    logic [34:0] got, exp;
    int total = 0, bad = 0;
    int so0, sl0, mg0, n0;
    bit ok;

    task automatic launch(input int s);
        @(posedge clk); #1 start_v[s] = 1'b1;
        @(posedge clk); #1 start_v = '0;
    endtask

    task automatic wait_done(output bit done_ok);
        done_ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!m_busy) begin done_ok = 1'b1; break; end
        end
        #1;
    endtask

    // which: 1 init_go, 2 ksa_go, 3 prga_go, 4 CHECK (busy with no go and no start_over)
    task automatic wait_state(input int which, output bit st_ok);
        st_ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if ((which == 1 && m_init_go) || (which == 2 && m_ksa_go) ||
                (which == 3 && m_prga_go) ||
                (which == 4 && m_busy && !m_init_go && !m_ksa_go && !m_prga_go && !m_start_over)) begin
                st_ok = 1'b1; break;
            end
        end
    endtask

    task automatic snap();
        so0 = so_total; sl0 = so_long; mg0 = multi_go; n0 = phase_log.size();
    endtask

    task automatic test_reset();
        sel = 2'd0;
        @(posedge clk); #3 rst = 1'b1;
        #1;
        total++;
        if (m_key !== 24'h0) begin bad++; $display("FAIL reset_key got=%h exp=%h", m_key, 24'h0); end
        total++;
        if ({m_init_go, m_ksa_go, m_prga_go, m_start_over, m_busy, m_found, m_fail, m_tmo} !== 8'h00) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=00000000",
                {m_init_go, m_ksa_go, m_prga_go, m_start_over, m_busy, m_found, m_fail, m_tmo});
        end
        total++;
        if ({m_s_addr, m_s_wrdata, m_s_wren} !== 17'h0) begin
            bad++; $display("FAIL reset_mem got=%h exp=0", {m_s_addr, m_s_wrdata, m_s_wren});
        end
        total++;
        if (o_key[2] !== 24'd5) begin bad++; $display("FAIL reset_key_c got=%h exp=%h", o_key[2], 24'd5); end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_first_key();
        logic [5:0] ord;
        sel = 2'd0; pass_mode = 1; snap();
        exp_q.push_back({1'b1, 1'b0, 1'b0, 24'h000000, 8'd0});
        launch(0);
        wait_done(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL first_key_wait got=busy exp=idle"); end
        got = {m_found, m_fail, m_tmo, m_key, 8'(so_total - so0)};
        exp = exp_q.pop_front();
        total++;
        if (got !== exp) begin bad++; $display("FAIL first_key_result got=%h exp=%h", got, exp); end
        ord = (phase_log.size() == n0 + 3) ? {phase_log[n0], phase_log[n0+1], phase_log[n0+2]} : 6'h00;
        total++;
        if (ord !== 6'b01_10_11) begin bad++; $display("FAIL first_key_order got=%b exp=011011", ord); end
        total++;
        if (multi_go !== mg0) begin bad++; $display("FAIL first_key_onehot got=%0d exp=%0d", multi_go, mg0); end
    endtask

    task automatic test_search_hit();
        sel = 2'd0; pass_mode = 2; snap();
        exp_q.push_back({1'b1, 1'b0, 1'b0, 24'h000003, 8'd3});
        launch(0);
        wait_state(2, ok);
        launch(0);   // start while busy must be ignored
        #1;
        total++;
        if ({m_ksa_go, m_key} !== {1'b1, 24'h0}) begin
            bad++; $display("FAIL hit_start_ignored got=%h exp=%h", {m_ksa_go, m_key}, {1'b1, 24'h0});
        end
        wait_done(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL hit_wait got=busy exp=idle"); end
        got = {m_found, m_fail, m_tmo, m_key, 8'(so_total - so0)};
        exp = exp_q.pop_front();
        total++;
        if (got !== exp) begin bad++; $display("FAIL hit_result got=%h exp=%h", got, exp); end
        total++;
        if (so_long !== sl0) begin bad++; $display("FAIL hit_pulse_width got=%0d exp=%0d", so_long, sl0); end
    endtask

    task automatic test_exhaust();
        sel = 2'd1; pass_mode = 0; snap();
        exp_q.push_back({1'b0, 1'b1, 1'b0, 24'd2, 8'd2});
        launch(1);
        wait_done(ok);
        got = {m_found, m_fail, m_tmo, m_key, 8'(so_total - so0)};
        exp = exp_q.pop_front();
        total++;
        if (got !== exp || !ok) begin bad++; $display("FAIL exhaust_result got=%h exp=%h", got, exp); end
    endtask

    task automatic test_back_to_back();
        sel = 2'd1; pass_mode = 1; snap();
        exp_q.push_back({1'b1, 1'b0, 1'b0, 24'd0, 8'd0});
        launch(1);
        wait_done(ok);
        got = {m_found, m_fail, m_tmo, m_key, 8'(so_total - so0)};
        exp = exp_q.pop_front();
        total++;
        if (got !== exp || !ok) begin bad++; $display("FAIL restart_result got=%h exp=%h", got, exp); end
    endtask

    task automatic test_single_attempt();
        sel = 2'd2; pass_mode = 0; snap();
        exp_q.push_back({1'b0, 1'b1, 1'b0, 24'd5, 8'd0});
        launch(2);
        wait_done(ok);
        got = {m_found, m_fail, m_tmo, m_key, 8'(so_total - so0)};
        exp = exp_q.pop_front();
        total++;
        if (got !== exp || !ok) begin bad++; $display("FAIL single_attempt got=%h exp=%h", got, exp); end
    endtask

    task automatic test_arbitration();
        sel = 2'd0; pass_mode = 1; snap();
        exp_q.push_back({1'b1, 1'b0, 1'b0, 24'd0, 8'd0});
        launch(0);
        wait_state(1, ok);
        init_addr = 8'h11; init_wrdata = 8'h22; init_wren = 1'b1;
        ksa_addr = 8'h66; ksa_wrdata = 8'h77; ksa_wren = 1'b1;
        #1;
        total++;
        if ({m_s_addr, m_s_wrdata, m_s_wren} !== {8'h11, 8'h22, 1'b1}) begin
            bad++; $display("FAIL arb_init got=%h exp=%h", {m_s_addr, m_s_wrdata, m_s_wren}, {8'h11, 8'h22, 1'b1});
        end
        wait_state(2, ok);
        ksa_addr = 8'h55; ksa_wrdata = 8'hAA; ksa_wren = 1'b1;
        prga_addr = 8'h33; prga_wrdata = 8'h44; prga_wren = 1'b1;
        #1;
        total++;
        if ({m_s_addr, m_s_wrdata, m_s_wren} !== {8'h55, 8'hAA, 1'b1}) begin
            bad++; $display("FAIL arb_ksa got=%h exp=%h", {m_s_addr, m_s_wrdata, m_s_wren}, {8'h55, 8'hAA, 1'b1});
        end
        wait_state(4, ok);
        #1;
        total++;
        if ({ok, m_s_addr, m_s_wrdata, m_s_wren} !== {1'b1, 17'h0}) begin
            bad++; $display("FAIL arb_check got=%h exp=%h", {ok, m_s_addr, m_s_wrdata, m_s_wren}, {1'b1, 17'h0});
        end
        wait_done(ok);
        init_wren = 1'b0; ksa_wren = 1'b0; prga_wren = 1'b0;
        got = {m_found, m_fail, m_tmo, m_key, 8'(so_total - so0)};
        exp = exp_q.pop_front();
        total++;
        if (got !== exp || !ok) begin bad++; $display("FAIL arb_result got=%h exp=%h", got, exp); end
    endtask

    task automatic test_abort();
        sel = 2'd0; pass_mode = 1;
        launch(0);
        wait_state(2, ok);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({ok, m_init_go, m_ksa_go, m_prga_go, m_busy, m_found, m_key} !== {1'b1, 29'h0}) begin
            bad++; $display("FAIL abort got=%h exp=%h",
                {ok, m_init_go, m_ksa_go, m_prga_go, m_busy, m_found, m_key}, {1'b1, 29'h0});
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (m_busy !== 1'b0) begin bad++; $display("FAIL abort_stays_idle got=%b exp=0", m_busy); end
    endtask

    task automatic test_stall();
        int cnt;
        sel = 2'd0; pass_mode = 1; stall_ksa = 1'b1; snap();
`ifdef RC4_PHASE_TIMEOUT_EN
        exp_q.push_back({1'b0, 1'b1, 1'b1, 24'd0, 8'd0});
        launch(0);
        wait_state(2, ok);
        cnt = ok ? 1 : 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_ksa_go) cnt++; else break;
        end
        #1;
        total++;
        if (cnt !== 50) begin bad++; $display("FAIL timeout_cycles got=%0d exp=50", cnt); end
        got = {m_found, m_fail, m_tmo, m_key, 8'(so_total - so0)};
        exp = exp_q.pop_front();
        total++;
        if (got !== exp) begin bad++; $display("FAIL timeout_result got=%h exp=%h", got, exp); end
        total++;
        if ({m_init_go, m_ksa_go, m_prga_go, m_busy} !== 4'b0) begin
            bad++; $display("FAIL timeout_go got=%b exp=0000", {m_init_go, m_ksa_go, m_prga_go, m_busy});
        end
        stall_ksa = 1'b0;
        launch(0);
        total++;
        if (m_tmo !== 1'b0) begin bad++; $display("FAIL timeout_clear got=%b exp=0", m_tmo); end
        wait_done(ok);
`else
        exp_q.push_back({1'b1, 1'b0, 1'b0, 24'd0, 8'd0});
        launch(0);
        wait_state(2, ok);
        repeat (200) @(negedge clk);
        #1;
        total++;
        if ({ok, m_ksa_go, m_busy, m_tmo} !== 4'b1110) begin
            bad++; $display("FAIL stall_wait got=%b exp=1110", {ok, m_ksa_go, m_busy, m_tmo});
        end
        stall_ksa = 1'b0;
        wait_done(ok);
        got = {m_found, m_fail, m_tmo, m_key, 8'(so_total - so0)};
        exp = exp_q.pop_front();
        total++;
        if (got !== exp || !ok) begin bad++; $display("FAIL stall_result got=%h exp=%h", got, exp); end
`endif
        stall_ksa = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_first_key();
        test_search_hit();
        test_exhaust();
        test_back_to_back();
        test_single_attempt();
        test_arbitration();
        test_abort();
        test_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
